// File: rtl/bcd_seq_ctrl_pkg.sv
// bcd_pkg: state encoding and add-3 constants shared by the BCD sequencer.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL = 4'd3;
endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// bcd_seq_ctrl_if: start/ready/done handshake and result bus of the BCD sequencer.
// Optional blank flags present when BCD_SEQ_BLANK_EN is defined.
interface bcd_seq_ctrl_if import bcd_pkg::*; #(parameter int WIDTH = 8, parameter int DIGITS = 3);
  logic start;
  logic [WIDTH-1:0] bin_in;
  logic ready;
  logic busy;
  logic done;
  logic [DIGIT_W*DIGITS-1:0] bcd_out;
`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank;
  modport master (output start, bin_in, input ready, busy, done, bcd_out, blank);
  modport slave (input start, bin_in, output ready, busy, done, bcd_out, blank);
`else
  modport master (output start, bin_in, input ready, busy, done, bcd_out);
  modport slave (input start, bin_in, output ready, busy, done, bcd_out);
`endif
endinterface

// File: rtl/bcd_seq_ctrl_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to digits of 5 or more.
module bcd_add3 import bcd_pkg::*; (
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);
  assign d_o = (d_i >= ADD3_THRESH) ? d_i + ADD3_VAL : d_i;
endmodule

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: iterative binary-to-BCD converter, one double-dabble shift per clock.
// Optional BCD_SEQ_BLANK_EN adds leading-zero blank flags registered with bcd_out.
module bcd_seq_ctrl import bcd_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst_n,
  bcd_seq_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int BCD_W = DIGIT_W * DIGITS;
  state_e state_q;
  logic [WIDTH-1:0] bin_q;
  logic [BCD_W-1:0] scratch_q, corr, scratch_d, bcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.d_i(scratch_q[DIGIT_W*i +: DIGIT_W]), .d_o(corr[DIGIT_W*i +: DIGIT_W]));
  end
  assign scratch_d = {corr[BCD_W-2:0], bin_q[WIDTH-1]};
  assign last = cnt_q == CNT_W'(WIDTH - 1);
`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic z;
  always_comb begin
    z = 1'b1;
    blank_d = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (scratch_d[DIGIT_W*i +: DIGIT_W] == '0);
      blank_d[i] = z;
    end
  end
  assign bus.blank = blank_q;
`endif
  // the result is captured on the final shift so it is valid during DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q <= '0;
      scratch_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
`ifdef BCD_SEQ_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          bin_q <= bus.bin_in;
          scratch_q <= '0;
          cnt_q <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bin_q <= bin_q << 1;
          scratch_q <= scratch_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            bcd_q <= scratch_d;
`ifdef BCD_SEQ_BLANK_EN
            blank_q <= blank_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.busy = state_q == SHIFT;
  assign bus.done = state_q == DONE;
  assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: randomized self-checking bench against a decimal-arithmetic reference.
module tb_bcd_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] last_ref = '0;
  bcd_seq_ctrl_if #(.WIDTH(8), .DIGITS(3)) bus ();
  bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic convert(input int v, input bit inject);
    int lat, nbusy, nready;
    bit got;
    lat = 0; nbusy = 0; nready = 0; got = 0;
    bus.start = 1'b1;
    bus.bin_in = 8'(v);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      bus.start = inject && lat == 3;
      bus.bin_in = (inject && lat == 3) ? 8'd7 : 8'($urandom);
      check("onehot", int'(bus.ready) + int'(bus.busy) + int'(bus.done), 1);
      if (bus.busy) nbusy++;
      if (bus.ready) nready++;
      if (bus.done) got = 1;
      else check("hold", bus.bcd_out, last_ref);
    end
    check("latency", lat, 9);
    check("busy_cycles", nbusy, 8);
    check("ready_low", nready, 0);
    check("bcd_out", bus.bcd_out, to_bcd(v));
`ifdef BCD_SEQ_BLANK_EN
    check("blank", bus.blank, {v < 100, v < 10, 1'b0});
`endif
    last_ref = to_bcd(v);
    @(negedge clk);
    check("ready_after", bus.ready, 1);
    check("single_done", bus.done, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.bin_in = '0;
    #12;
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd", bus.bcd_out, 0);
`ifdef BCD_SEQ_BLANK_EN
    check("rst_blank", bus.blank, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convert(255, 0);
    convert(0, 0);
    convert(99, 0);
    convert(128, 1);
    bus.start = 1'b1;
    bus.bin_in = 8'd200;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_bcd", bus.bcd_out, 0);
    last_ref = '0;
    @(negedge clk);
    rst_n = 1'b1;
    convert(45, 0);
    for (int v = 0; v < 256; v++) convert(v, 0);
    repeat (40) convert(int'($urandom_range(0, 255)), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_seq_ctrl.md
Name: bcd_seq_ctrl

Overview:
Sequential controller for the 8-bit binary-to-BCD path, using iterative shift-and-add-3 (double-dabble) over one shared add-3 stage per digit.
- Replaces the wide per-digit combinational logic (hundreds/tens/units).
- Performs one shift per clock and exposes a start/ready/done handshake.
- Holds the last result for the display drivers.

Parameters:
- WIDTH, 8, binary input width; legal range 4..16.
- DIGITS, 3, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled only when ready=1.
- bin_in  in  WIDTH  binary operand; captured on the accepted start.
- ready  out  1  1 in IDLE.
- busy  out  1  1 in SHIFT.
- done  out  1  one-cycle pulse when a new result is on bcd_out.
- bcd_out  out  4*DIGITS  result; digit i at bits [4i+3:4i], digit 0 = units.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, ready=1, busy=0, done=0, bcd_out=0, internal shift/count registers=0. Applies immediately, including mid-conversion; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, load bin_reg<=bin_in, clear scratch digits, cnt<=0, go to SHIFT.
  - On start=0, stay in IDLE.
- SHIFT, each cycle:
  - Correct every scratch digit: if digit>=5, add 3 (4-bit, no carry out).
  - Shift {scratch, bin_reg} left by 1; bin_reg MSB enters digit 0 LSB.
  - cnt<=cnt+1. When cnt==WIDTH-1 (WIDTH-th shift), go to DONE.
- DONE (one cycle): bcd_out<=scratch registered, done=1, then go to IDLE.
- Latency: start accepted at edge N -> done=1 and bcd_out valid during cycle N+WIDTH+1 (9 cycles for WIDTH=8).
- start while busy or in DONE: ignored; no queuing.
- bin_in changes after capture: no effect.
- bcd_out changes only on the DONE transition or reset; holds between conversions.
- ready, busy, done are mutually exclusive; decoded from registered state, glitch-free.
- cnt width: clog2(WIDTH); no wrap, since it is cleared on every accept.

Optional Feature:
Macro BCD_SEQ_BLANK_EN.
- Defined: adds output blank [DIGITS-1:0], registered together with bcd_out.
  - blank[i]=1 iff digits DIGITS-1..i are all zero, for i>=1.
  - blank[0]=0 always, so value 0 shows a single "0".
  - Reset value all zeros.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package bcd_pkg:
  - State encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - DIGIT_W=4, ADD3_THRESH=4'd5, ADD3_VAL=4'd3.
- Sub-module bcd_add3: combinational 4-bit digit in -> corrected digit out. Instantiated DIGITS times in a generate loop.
- The controller FSM, counter and shift register live in bcd_seq_ctrl.

Test Plan:
- bin_in=8'd255, start pulse -> done at cycle 9 after the accept; bcd_out=12'h255; busy high for cycles 1..8; ready low throughout.
- bin_in=0 -> bcd_out=12'h000. With BCD_SEQ_BLANK_EN: blank=3'b110.
- bin_in=8'd99 -> bcd_out=12'h099. With BCD_SEQ_BLANK_EN: blank=3'b100.
- Accept 8'd128, then at cycle 3 apply start=1 with bin_in=8'd7 -> ignored; result 12'h128; one done pulse only.
- Accept 8'd200, drop rst_n at cycle 4 -> immediately ready=1, busy=0, bcd_out=0. After release, start with 8'd45 -> 12'h045 nine cycles later.
- Sweep 0..255 back-to-back, restarting on each ready -> every bcd_out matches the decimal reference; bcd_out stable between done pulses.
